// File: rtl/rv32m_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : rv32m_pkg                                                         |
// | Brief  : Shared RV32M encodings, MDU state codes and divide constants.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rv32m_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MUL_EXEC = 3'd1;
    localparam logic [2:0] ST_DIV_EXEC = 3'd2;
    localparam logic [2:0] ST_DIV_FIX  = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    localparam int          DIV_ITERS     = 32;
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] value);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +----------------------------------------------------------------------------+
// | Module : div_step                                                          |
// | Brief  : One combinational restoring-division step (shift, trial subtract).|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          unused_rem_msb;

    // The partial remainder is always below the divisor, so its MSB is never set
    // on entry; the extra bit only matters for the borrow of the trial subtract.
    assign unused_rem_msb = i_rem[XLEN];
    assign shifted        = {i_rem[XLEN-1:0], i_quo[XLEN-1]};
    assign diff           = shifted - {1'b0, i_divisor};

    always_comb begin
        o_rem = shifted;
        o_quo = {i_quo[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            o_rem = diff;
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module : mdu_sequencer                                                     |
// | Brief  : RV32M sequencer: 1-cycle multiply, 32-step restoring divide.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mdu_sequencer
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [2:0]      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic              accept;
    logic              acc_signed, acc_neg1, acc_neg2;
    logic              mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, product;
    logic              div_by_zero, div_overflow, want_rem;
    logic [XLEN:0]     step_rem;
    logic [XLEN-1:0]   step_quo;

    div_step #(
        .XLEN(XLEN)
    ) u_div_step (
        .i_rem    (rem_q),
        .i_quo    (quo_q),
        .i_divisor(divisor_q),
        .o_rem    (step_rem),
        .o_quo    (step_quo)
    );

    assign accept     = START && !FLUSH && ((state_q == ST_IDLE) || (state_q == ST_FINISH));
    assign acc_signed = FUNCT3[2] && !FUNCT3[0];
    assign acc_neg1   = acc_signed && OPERAND1[XLEN-1];
    assign acc_neg2   = acc_signed && OPERAND2[XLEN-1];

    // Sign-extending both operands to 2*XLEN makes one unsigned multiplier
    // serve all four signedness combinations.
    assign mul_a_signed = (funct3_q == FUNCT3_MULH) || (funct3_q == FUNCT3_MULHSU);
    assign mul_b_signed = (funct3_q == FUNCT3_MULH);
    assign mul_a_ext    = {{XLEN{mul_a_signed && op1_q[XLEN-1]}}, op1_q};
    assign mul_b_ext    = {{XLEN{mul_b_signed && op2_q[XLEN-1]}}, op2_q};
    assign product      = mul_a_ext * mul_b_ext;

    assign want_rem     = funct3_q[1];
    assign div_by_zero  = (op2_q == '0);
    assign div_overflow = !funct3_q[0] && (op1_q == INT_MIN) && (op2_q == {XLEN{1'b1}});

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                state_d = ST_IDLE;
                if (accept) begin
                    funct3_d  = FUNCT3;
                    op1_d     = OPERAND1;
                    op2_d     = OPERAND2;
                    divisor_d = negate_if(acc_neg2, OPERAND2);
                    quo_d     = negate_if(acc_neg1, OPERAND1);
                    rem_d     = '0;
                    cnt_d     = CNT_W'(DIV_ITERS);
                    neg_quo_d = acc_neg1 ^ acc_neg2;
                    neg_rem_d = acc_neg1;
                    state_d   = FUNCT3[2] ? ST_DIV_EXEC : ST_MUL_EXEC;
                end
            end
            ST_MUL_EXEC: begin
                result_d = (funct3_q == FUNCT3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                state_d  = ST_FINISH;
            end
            ST_DIV_EXEC: begin
                if (div_by_zero) begin
                    result_d = want_rem ? op1_q : DIV0_QUOTIENT;
                    state_d  = ST_FINISH;
                end else if (div_overflow) begin
                    result_d = want_rem ? '0 : INT_MIN;
                    state_d  = ST_FINISH;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DIV_FIX;
                    end
                end
            end
            ST_DIV_FIX: begin
                result_d = want_rem ? negate_if(neg_rem_q, rem_q[XLEN-1:0])
                                    : negate_if(neg_quo_q, quo_q);
                state_d  = ST_FINISH;
            end
            default: state_d = ST_IDLE;
        endcase

        // Redirect abort: drop whatever was in flight and keep the old RESULT.
        if (FLUSH) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            funct3_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign BUSY   = (state_q == ST_MUL_EXEC) || (state_q == ST_DIV_EXEC) || (state_q == ST_DIV_FIX);
    assign DONE   = (state_q == ST_FINISH);
    assign RESULT = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module : tb_mdu_sequencer                                                  |
// | Brief  : Scoreboard bench for mdu_sequencer: latency, specials, flush.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mdu_sequencer;
    import rv32m_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [31:0] OPERAND1, OPERAND2;
    logic        FLUSH;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'h0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } op_t;

    mdu_sequencer #(.XLEN(32)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .FUNCT3  (FUNCT3),
        .OPERAND1(OPERAND1),
        .OPERAND2(OPERAND2),
        .FLUSH   (FLUSH),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every DONE pops the oldest expected result.
    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && DONE === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: RESULT=%h with nothing expected", RESULT);
            end else begin
                last_exp = exp_q.pop_front();
                if (RESULT !== last_exp) begin
                    n_fail++;
                    $display("FAIL result: got %h expected %h", RESULT, last_exp);
                end
            end
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, output int lat, output int busy_cyc);
        exp_q.push_back(exp);
        @(negedge CLK);
        START = 1'b1; FUNCT3 = f3; OPERAND1 = a; OPERAND2 = b;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 0; busy_cyc = 0;
        while (DONE !== 1'b1 && lat < 100) begin
            if (BUSY === 1'b1) busy_cyc++;
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic run_table(input op_t ops[], input string tag);
        int lat, busy_cyc;
        foreach (ops[i]) begin
            run_op(ops[i].f3, ops[i].a, ops[i].b, ops[i].exp, lat, busy_cyc);
            n_tests++;
            if (lat !== ops[i].lat || busy_cyc !== ops[i].lat) begin
                n_fail++;
                $display("FAIL %s_latency[%0d]: done after %0d edges busy %0d cycles, expected %0d",
                         tag, i, lat, busy_cyc, ops[i].lat);
            end
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; START = 1'b0; FLUSH = 1'b0;
        FUNCT3 = '0; OPERAND1 = '0; OPERAND2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        n_tests++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h, expected 0 0 00000000", BUSY, DONE, RESULT);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_mul();
        op_t ops[] = '{
            '{FUNCT3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1},
            '{FUNCT3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1},
            '{FUNCT3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1},
            '{FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 1},
            '{FUNCT3_MULH,   32'h8000_0000, 32'd2,        32'hFFFF_FFFF, 1},
            '{FUNCT3_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1}
        };
        run_table(ops, "mul");
    endtask

    task automatic test_div();
        op_t ops[] = '{
            '{FUNCT3_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33},
            '{FUNCT3_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33},
            '{FUNCT3_DIVU, 32'd100,       32'd7,        32'd14,        33},
            '{FUNCT3_REMU, 32'd100,       32'd7,        32'd2,         33},
            '{FUNCT3_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33},
            '{FUNCT3_REM,  32'd100,       32'hFFFF_FFF9, 32'd2,         33},
            '{FUNCT3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33},
            '{FUNCT3_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33},
            '{FUNCT3_DIV,  32'h8000_0000, 32'd2,        32'hC000_0000, 33}
        };
        run_table(ops, "div");
    endtask

    task automatic test_special();
        op_t ops[] = '{
            '{FUNCT3_DIVU, 32'd5,         32'd0,        32'hFFFF_FFFF, 1},
            '{FUNCT3_REM,  32'd5,         32'd0,        32'd5,         1},
            '{FUNCT3_REM,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1},
            '{FUNCT3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{FUNCT3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1}
        };
        run_table(ops, "special");
    endtask

    task automatic test_flush();
        int          dones;
        logic [31:0] prior;
        repeat (2) @(posedge CLK);
        prior = last_exp;
        @(negedge CLK);
        START = 1'b1; FUNCT3 = FUNCT3_DIVU; OPERAND1 = 32'd1000; OPERAND2 = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        n_tests++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== prior) begin
            n_fail++;
            $display("FAIL flush_abort: busy=%b done=%b result=%h, expected 0 0 %h", BUSY, DONE, RESULT, prior);
        end
        dones = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL flush_no_done: saw %0d DONE pulses, expected 0", dones);
        end

        @(negedge CLK);
        START = 1'b1; FLUSH = 1'b1; FUNCT3 = FUNCT3_MUL; OPERAND1 = 32'd9; OPERAND2 = 32'd9;
        @(posedge CLK); #1;
        START = 1'b0; FLUSH = 1'b0;
        dones = 0;
        repeat (3) begin
            if (BUSY === 1'b1 || DONE === 1'b1) dones++;
            @(posedge CLK); #1;
        end
        n_tests++;
        if (dones !== 0 || RESULT !== prior) begin
            n_fail++;
            $display("FAIL start_flush_drop: %0d active cycles result=%h, expected 0 and %h", dones, RESULT, prior);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busy_cyc;
        exp_q.push_back(32'd14);
        exp_q.push_back(32'd15);
        @(negedge CLK);
        START = 1'b1; FUNCT3 = FUNCT3_DIVU; OPERAND1 = 32'd100; OPERAND2 = 32'd7;
        @(posedge CLK); #1;
        FUNCT3 = FUNCT3_MUL; OPERAND1 = 32'd3; OPERAND2 = 32'd5;
        lat = 0; busy_cyc = 0;
        while (DONE !== 1'b1 && lat < 100) begin
            if (BUSY === 1'b1) busy_cyc++;
            @(posedge CLK); #1;
            lat++;
        end
        n_tests++;
        if (lat !== 33 || busy_cyc !== 33) begin
            n_fail++;
            $display("FAIL held_start_ignored: done after %0d busy %0d, expected 33 33", lat, busy_cyc);
        end
        @(posedge CLK); #1;
        START = 1'b0;
        n_tests++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL finish_accept: busy=%b done=%b, expected 1 0", BUSY, DONE);
        end
        @(posedge CLK); #1;
        n_tests++;
        if (DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b, expected 1", DONE);
        end
    endtask

    task automatic test_async_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        START = 1'b1; FUNCT3 = FUNCT3_DIV; OPERAND1 = 32'd77; OPERAND2 = 32'd4;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        n_tests++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b result=%h, expected 0 0 00000000", BUSY, DONE, RESULT);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (40) @(posedge CLK);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_async_reset();
        repeat (3) @(posedge CLK);
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results never produced, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
